// File: rtl/jogo_memoria_pkg.sv
// Shared state codes, LFSR constants and default sizing for the sequence-memory game.
package jogo_memoria_pkg;

  localparam logic [3:0] EST_INICIAL  = 4'h0;
  localparam logic [3:0] EST_GERA     = 4'h1;
  localparam logic [3:0] EST_MOSTRA   = 4'h2;
  localparam logic [3:0] EST_PAUSA    = 4'h3;
  localparam logic [3:0] EST_ESPERA   = 4'h4;
  localparam logic [3:0] EST_REGISTRA = 4'h5;
  localparam logic [3:0] EST_COMPARA  = 4'h6;
  localparam logic [3:0] EST_PROXIMA  = 4'h7;
  localparam logic [3:0] EST_RODADA   = 4'h8;
  localparam logic [3:0] EST_GANHOU   = 4'h9;
  localparam logic [3:0] EST_PERDEU   = 4'hA;
  localparam logic [3:0] EST_TIMEOUT  = 4'hB;

  localparam int LFSR_W = 16;
  // Fibonacci taps 16,14,13,11 as bit positions 15,13,12,10
  localparam logic [LFSR_W-1:0] LFSR_TAPS          = 16'hB400;
  localparam logic [LFSR_W-1:0] LFSR_SEMENTE_RESET = 16'h0001;
  localparam logic [7:0]        LFSR_SEMENTE_LSB   = 8'h01;

  localparam int N_BOTOES_PADRAO       = 4;
  localparam int PROFUNDIDADE_PADRAO   = 16;
  localparam int LED_CICLOS_PADRAO     = 1000;
  localparam int TIMEOUT_CICLOS_PADRAO = 5000;

  function automatic logic [LFSR_W-1:0] lfsr_proximo(input logic [LFSR_W-1:0] v);
    return {v[LFSR_W-2:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/gerador_lfsr.sv
// 16-bit Fibonacci LFSR with synchronous load (priority) and step enable; exposes low SAIDA_W bits.
// One step per enabled cycle; no backpressure.
module gerador_lfsr
  import jogo_memoria_pkg::*;
#(
  parameter int SAIDA_W = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               carga,
  input  logic               habilita,
  input  logic [LFSR_W-1:0]  semente,
  output logic [SAIDA_W-1:0] valor
);

  logic [LFSR_W-1:0] registro;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      registro <= LFSR_SEMENTE_RESET;
    else if (carga)
      registro <= semente;
    else if (habilita)
      registro <= lfsr_proximo(registro);
  end

  assign valor = registro[SAIDA_W-1:0];

endmodule

// File: rtl/jogo_memoria_param.sv
// Parametrised sequence-memory game: LFSR-generated sequence, full or progressive rounds.
// Verdict 3 cycles after a press edge; optional play timeout under JOGO_MEMORIA_TIMEOUT_EN.
module jogo_memoria_param
  import jogo_memoria_pkg::*;
#(
  parameter int N_BOTOES       = N_BOTOES_PADRAO,
  parameter int PROFUNDIDADE   = PROFUNDIDADE_PADRAO,
  parameter int LED_CICLOS     = LED_CICLOS_PADRAO,
  parameter int TIMEOUT_CICLOS = TIMEOUT_CICLOS_PADRAO
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                jogar,
  input  logic                modo,
  input  logic [7:0]          semente,
  input  logic [N_BOTOES-1:0] botoes,
  output logic [N_BOTOES-1:0] leds,
  output logic                ganhou,
  output logic                perdeu,
  output logic                pronto,
  output logic                timeout,
  output logic [3:0]          db_estado,
  output logic [4:0]          db_endereco,
  output logic [4:0]          db_rodada
);

  localparam int BW = $clog2(N_BOTOES);
  localparam int AW = $clog2(PROFUNDIDADE);
  localparam int LW = (LED_CICLOS > 1) ? $clog2(LED_CICLOS) : 1;

  localparam logic [AW-1:0]       ULT     = AW'(PROFUNDIDADE - 1);
  localparam logic [AW-1:0]       UM_A    = AW'(1);
  localparam logic [LW-1:0]       LED_FIM = LW'(LED_CICLOS - 1);
  localparam logic [LW-1:0]       UM_L    = LW'(1);
  localparam logic [N_BOTOES-1:0] UM_B    = N_BOTOES'(1);

  if (N_BOTOES < 2 || N_BOTOES > 8 || (N_BOTOES & (N_BOTOES - 1)) != 0 ||
      PROFUNDIDADE < 2 || PROFUNDIDADE > 32 || LED_CICLOS < 1 || TIMEOUT_CICLOS < 2)
  begin : g_param_invalido
    $error("jogo_memoria_param: parameter out of supported range");
  end

  logic [3:0]          estado;
  logic [AW-1:0]       endereco;
  logic [AW-1:0]       rodada;
  logic [LW-1:0]       cnt_led;
  logic                modo_reg;
  logic [N_BOTOES-1:0] captura;
  logic                botao_ant;
  logic                borda;
  logic [BW-1:0]       lfsr_valor;
  logic                lfsr_carga;
  logic [N_BOTOES-1:0] esperado;
  logic                final_ou_inicial;

  logic [BW-1:0] mem [PROFUNDIDADE];

  assign final_ou_inicial = (estado == EST_INICIAL) || (estado == EST_GANHOU) ||
                            (estado == EST_PERDEU)  || (estado == EST_TIMEOUT);
  assign lfsr_carga = final_ou_inicial && jogar;
  assign borda      = (|botoes) && !botao_ant;
  assign esperado   = UM_B << mem[endereco];

  gerador_lfsr #(.SAIDA_W(BW)) u_lfsr (
    .clock    (clock),
    .reset    (reset),
    .carga    (lfsr_carga),
    .habilita (estado == EST_GERA),
    .semente  ({semente, LFSR_SEMENTE_LSB}),
    .valor    (lfsr_valor)
  );

  // Sequence RAM has no reset: every start rewrites all entries during GERA.
  always_ff @(posedge clock) begin
    if (estado == EST_GERA)
      mem[endereco] <= lfsr_valor;
  end

`ifdef JOGO_MEMORIA_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CICLOS);
  localparam logic [TW-1:0] TO_FIM = TW'(TIMEOUT_CICLOS - 1);
  localparam logic [TW-1:0] UM_T   = TW'(1);
  logic [TW-1:0] cnt_timeout;

  // Any exit from ESPERA (including an accepted play) restarts the count.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      cnt_timeout <= '0;
    else if (estado != EST_ESPERA)
      cnt_timeout <= '0;
    else if (cnt_timeout != TO_FIM)
      cnt_timeout <= cnt_timeout + UM_T;
  end
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado    <= EST_INICIAL;
      endereco  <= '0;
      rodada    <= '0;
      cnt_led   <= '0;
      modo_reg  <= 1'b0;
      captura   <= '0;
      botao_ant <= 1'b0;
    end else begin
      botao_ant <= |botoes;
      case (estado)
        EST_INICIAL, EST_GANHOU, EST_PERDEU, EST_TIMEOUT: begin
          if (jogar) begin
            modo_reg <= modo;
            endereco <= '0;
            rodada   <= '0;
            cnt_led  <= '0;
            estado   <= EST_GERA;
          end
        end
        EST_GERA: begin
          if (endereco == ULT) begin
            endereco <= '0;
            rodada   <= modo_reg ? '0 : ULT;
            estado   <= EST_MOSTRA;
          end else begin
            endereco <= endereco + UM_A;
          end
        end
        EST_MOSTRA: begin
          if (cnt_led == LED_FIM) begin
            cnt_led <= '0;
            estado  <= EST_PAUSA;
          end else begin
            cnt_led <= cnt_led + UM_L;
          end
        end
        EST_PAUSA: begin
          if (cnt_led == LED_FIM) begin
            cnt_led <= '0;
            if (endereco < rodada) begin
              endereco <= endereco + UM_A;
              estado   <= EST_MOSTRA;
            end else begin
              endereco <= '0;
              estado   <= EST_ESPERA;
            end
          end else begin
            cnt_led <= cnt_led + UM_L;
          end
        end
        EST_ESPERA: begin
          // A press edge takes priority over an expiring timeout.
          if (borda) begin
            captura <= botoes;
            estado  <= EST_REGISTRA;
          end
`ifdef JOGO_MEMORIA_TIMEOUT_EN
          else if (cnt_timeout == TO_FIM) begin
            estado <= EST_TIMEOUT;
          end
`endif
        end
        EST_REGISTRA: estado <= EST_COMPARA;
        EST_COMPARA: begin
          if (captura != esperado)
            estado <= EST_PERDEU;
          else if (endereco < rodada)
            estado <= EST_PROXIMA;
          else if (rodada == ULT)
            estado <= EST_GANHOU;
          else
            estado <= EST_RODADA;
        end
        EST_PROXIMA: begin
          endereco <= endereco + UM_A;
          estado   <= EST_ESPERA;
        end
        EST_RODADA: begin
          rodada   <= rodada + UM_A;
          endereco <= '0;
          estado   <= EST_MOSTRA;
        end
        default: estado <= EST_INICIAL;
      endcase
    end
  end

  always_comb begin
    leds = '0;
    if (estado == EST_MOSTRA)
      leds = esperado;
    else if (estado == EST_ESPERA)
      leds = botoes;
  end

  assign ganhou      = (estado == EST_GANHOU);
  assign perdeu      = (estado == EST_PERDEU) || (estado == EST_TIMEOUT);
  assign pronto      = (estado == EST_GANHOU) || (estado == EST_PERDEU) || (estado == EST_TIMEOUT);
`ifdef JOGO_MEMORIA_TIMEOUT_EN
  assign timeout     = (estado == EST_TIMEOUT);
`else
  assign timeout     = 1'b0;
`endif
  assign db_estado   = estado;
  assign db_endereco = 5'(endereco);
  assign db_rodada   = 5'(rodada);

endmodule

// File: tb/tb_jogo_memoria_param.sv
// Directed bench for jogo_memoria_param; game-rule model predicts outputs every cycle.
module tb_jogo_memoria_param;

  localparam int NB   = 4;
  localparam int PROF = 4;
  localparam int LEDC = 4;
  localparam int TOC  = 20;

  // {ganhou, perdeu, pronto, timeout}
  localparam logic [3:0] F_NADA    = 4'b0000;
  localparam logic [3:0] F_GANHOU  = 4'b1010;
  localparam logic [3:0] F_PERDEU  = 4'b0110;
  localparam logic [3:0] F_TIMEOUT = 4'b0111;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          jogar = 1'b0;
  logic          modo = 1'b0;
  logic [7:0]    semente = 8'h00;
  logic [NB-1:0] botoes = '0;
  logic [NB-1:0] leds;
  logic          ganhou, perdeu, pronto, timeout;
  logic [3:0]    db_estado;
  logic [4:0]    db_endereco, db_rodada;

  always #5 clock = ~clock;

  jogo_memoria_param #(
    .N_BOTOES(NB), .PROFUNDIDADE(PROF), .LED_CICLOS(LEDC), .TIMEOUT_CICLOS(TOC)
  ) dut (
    .clock(clock), .reset(reset), .jogar(jogar), .modo(modo), .semente(semente),
    .botoes(botoes), .leds(leds), .ganhou(ganhou), .perdeu(perdeu), .pronto(pronto),
    .timeout(timeout), .db_estado(db_estado), .db_endereco(db_endereco), .db_rodada(db_rodada)
  );

  int n_asserts = 0;
  int n_falhas  = 0;

  logic          chk = 1'b0;
  logic [3:0]    e_est = '0;
  logic [NB-1:0] e_leds = '0;
  logic [3:0]    e_flg = '0;
  int            seq [PROF];

  task automatic verifica(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
    n_asserts++;
    if (atual !== esperado) begin
      n_falhas++;
      $display("FAIL %s at t=%0t: got %0h, expected %0h", nome, $time, atual, esperado);
    end
  endtask

  // Packed as {estado, leds, ganhou, perdeu, pronto, timeout}
  always @(negedge clock) begin
    if (chk)
      verifica("saidas", 32'({db_estado, leds, ganhou, perdeu, pronto, timeout}),
               32'({e_est, e_leds, e_flg}));
  end

  function automatic logic [NB-1:0] oh(input int k);
    logic [NB-1:0] r;
    r = '0;
    r[k] = 1'b1;
    return r;
  endfunction

  // Entry i is the low bits of the i-th LFSR state, starting with the loaded seed.
  task automatic modelo_seq(input logic [7:0] sd);
    int s;
    s = int'(sd) * 256 + 1;
    for (int i = 0; i < PROF; i++) begin
      seq[i] = s % NB;
      s = ((s * 2) % 65536) + (((s >> 15) ^ (s >> 13) ^ (s >> 12) ^ (s >> 10)) & 1);
    end
  endtask

  task automatic tick(input logic [3:0] est, input logic [NB-1:0] lds, input logic [3:0] flg);
    e_est  = est;
    e_leds = lds;
    e_flg  = flg;
    chk    = 1'b1;
    @(negedge clock);
    @(posedge clock);
    #1;
  endtask

  // passo_erro: step index that gets a bad play (-1 none); tipo_erro 1 = wrong button, 2 = two buttons.
  task automatic partida(input logic m, input logic [7:0] sd, input logic [3:0] est0,
                         input logic [3:0] flg0, input int passo_erro, input int tipo_erro,
                         input bit segura, input bit ocioso, input bit jogar_espera);
    int rod_ini;
    logic [NB-1:0] v;
    modelo_seq(sd);
    modo = m; semente = sd; jogar = 1'b1;
    tick(est0, '0, flg0);
    jogar = 1'b0; modo = ~m; semente = ~sd;
    repeat (PROF) tick(4'h1, '0, F_NADA);
    rod_ini = m ? 0 : PROF - 1;
    verifica("rodada_inicial", 32'(db_rodada), 32'(rod_ini));
    verifica("endereco_inicial", 32'(db_endereco), 32'd0);
    for (int rod = rod_ini; rod < PROF; rod++) begin
      for (int i = 0; i <= rod; i++) begin
        repeat (LEDC) tick(4'h2, oh(seq[i]), F_NADA);
        repeat (LEDC) tick(4'h3, '0, F_NADA);
      end
      if (ocioso) begin
`ifdef JOGO_MEMORIA_TIMEOUT_EN
        repeat (TOC) tick(4'h4, '0, F_NADA);
        repeat (3) tick(4'hB, '0, F_TIMEOUT);
`else
        repeat (200) tick(4'h4, '0, F_NADA);
`endif
        return;
      end
      for (int i = 0; i <= rod; i++) begin
        if (jogar_espera && i == 0) begin
          jogar = 1'b1;
          tick(4'h4, '0, F_NADA);
          jogar = 1'b0;
        end
        v = oh(seq[i]);
        if (i == passo_erro)
          v = (tipo_erro == 1) ? oh((seq[i] + 1) % NB) : (v | oh((seq[i] + 1) % NB));
        botoes = v;
        tick(4'h4, v, F_NADA);
        if (!(segura && i == 0)) botoes = '0;
        tick(4'h5, '0, F_NADA);
        tick(4'h6, '0, F_NADA);
        if (i == passo_erro) begin
          repeat (3) tick(4'hA, '0, F_PERDEU);
          return;
        end
        if (i < rod) begin
          tick(4'h7, '0, F_NADA);
          if (segura && i == 0) begin
            tick(4'h4, v, F_NADA);
            botoes = '0;
            tick(4'h4, '0, F_NADA);
          end
        end else if (rod == PROF - 1) begin
          repeat (3) tick(4'h9, '0, F_GANHOU);
          return;
        end else begin
          tick(4'h8, '0, F_NADA);
        end
      end
    end
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    repeat (3) tick(4'h0, '0, F_NADA);
    verifica("reset_rodada", 32'(db_rodada), 32'd0);

    modelo_seq(8'h3C);
    verifica("seq0", 32'(seq[0]), 32'd1);
    verifica("seq1", 32'(seq[1]), 32'd3);
    verifica("seq2", 32'(seq[2]), 32'd2);
    verifica("seq3", 32'(seq[3]), 32'd1);

    partida(1'b0, 8'h3C, 4'h0, F_NADA, -1, 0, 1'b1, 1'b0, 1'b0);
    partida(1'b1, 8'h3C, 4'h9, F_GANHOU, -1, 0, 1'b0, 1'b0, 1'b0);
    partida(1'b0, 8'hA5, 4'h9, F_GANHOU, 1, 1, 1'b0, 1'b0, 1'b1);
    partida(1'b0, 8'h3C, 4'hA, F_PERDEU, 0, 2, 1'b0, 1'b0, 1'b0);
`ifdef JOGO_MEMORIA_TIMEOUT_EN
    partida(1'b1, 8'h3C, 4'hA, F_PERDEU, -1, 0, 1'b0, 1'b1, 1'b0);
`else
    partida(1'b1, 8'h3C, 4'hA, F_PERDEU, -1, 0, 1'b0, 1'b1, 1'b0);
    verifica("sem_timeout_espera", 32'(db_estado), 32'h4);
`endif

    reset = 1'b1;
    tick(4'h0, '0, F_NADA);
    reset = 1'b0;
    tick(4'h0, '0, F_NADA);
    modelo_seq(8'h3C);
    modo = 1'b0; semente = 8'h3C; jogar = 1'b1;
    tick(4'h0, '0, F_NADA);
    jogar = 1'b0;
    repeat (PROF) tick(4'h1, '0, F_NADA);
    repeat (2) tick(4'h2, oh(seq[0]), F_NADA);
    chk = 1'b0;
    verifica("leds_antes_reset", 32'(leds), 32'(oh(seq[0])));
    #2 reset = 1'b1;
    #1;
    verifica("reset_async_leds", 32'(leds), 32'd0);
    verifica("reset_async_estado", 32'(db_estado), 32'h0);
    verifica("reset_async_flags", 32'({ganhou, perdeu, pronto, timeout}), 32'd0);
    tick(4'h0, '0, F_NADA);
    reset = 1'b0;
    repeat (2) tick(4'h0, '0, F_NADA);
    chk = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_falhas);
    $finish;
  end

endmodule
